// File: rtl/conversor_pkg.sv
// Shared types and constants for the stopwatch display converter.
// State encoding, segment codes and default sizes.
package conversor_pkg;

    localparam int WIDTH_DEF  = 15;
    localparam int DIGITS_DEF = 5;

    typedef enum logic [1:0] {
        OCIOSO,
        CONVERTE,
        PUBLICA
    } estado_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

endpackage

// File: rtl/bcd_para_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes and an asserted blank input give all segments off.
module bcd_para_7seg
    import conversor_pkg::*;
(
    input  logic [3:0] digito,
    input  logic       apaga,
    output logic [6:0] seg
);

    // Look up the segment pattern, blank overrides the digit
    always_comb begin
        seg = SEG_BLANK;
        if (!apaga) begin
            case (digito)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/conversor_display.sv
// Binary to BCD (sequential double-dabble) and 7-segment display stage.
// Optional leading-zero blanking of hex4..hex2 with CONVERSOR_BLANK_EN.
module conversor_display
    import conversor_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      valor,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic                  ocupado,
    output logic                  pronto
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

`ifdef CONVERSOR_BLANK_EN
    localparam logic [4:0] APAGA_RST = 5'b11100;
`else
    localparam logic [4:0] APAGA_RST = 5'b00000;
`endif

    estado_t           est_q, est_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  lat_q, lat_d;
    logic [WIDTH-1:0]  ult_q, ult_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              pronto_q, pronto_d;
    logic [6:0]        hex_q [5];
    logic [6:0]        hex_d [5];
    logic [6:0]        seg_w [5];
    logic [4:0]        apaga;
    logic [BW-1:0]     adj;
    logic [BW+WIDTH-1:0] desl;

    // Add 3 to every nibble of 5 or more before the shift
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    assign desl = {adj, sr_q} << 1;

    // Leading-zero suppression decided on the finished accumulator
    always_comb begin
        apaga = '0;
`ifdef CONVERSOR_BLANK_EN
        apaga[4] = (acc_q[19:16] == 4'd0);
        apaga[3] = apaga[4] && (acc_q[15:12] == 4'd0);
        apaga[2] = apaga[3] && (acc_q[11:8] == 4'd0);
`endif
    end

    for (genvar g = 0; g < 5; g++) begin : g_dec
        bcd_para_7seg u_dec (
            .digito (acc_q[4*g +: 4]),
            .apaga  (apaga[g]),
            .seg    (seg_w[g])
        );
    end

    // Next-state and datapath control for sample, convert, publish
    always_comb begin
        est_d    = est_q;
        sr_d     = sr_q;
        lat_d    = lat_q;
        ult_d    = ult_q;
        acc_d    = acc_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        hex_d    = hex_q;
        pronto_d = 1'b0;
        unique case (est_q)
            OCIOSO: begin
                if (valor != ult_q) begin
                    sr_d  = valor;
                    lat_d = valor;
                    acc_d = '0;
                    cnt_d = '0;
                    est_d = CONVERTE;
                end
            end
            CONVERTE: begin
                acc_d = desl[BW+WIDTH-1:WIDTH];
                sr_d  = desl[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    est_d = PUBLICA;
            end
            PUBLICA: begin
                bcd_d    = acc_q;
                hex_d    = seg_w;
                ult_d    = lat_q;
                pronto_d = 1'b1;
                est_d    = OCIOSO;
            end
            default: est_d = OCIOSO;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            est_q    <= OCIOSO;
            sr_q     <= '0;
            lat_q    <= '0;
            ult_q    <= '0;
            acc_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            pronto_q <= 1'b0;
            for (int i = 0; i < 5; i++)
                hex_q[i] <= APAGA_RST[i] ? SEG_BLANK : SEG_0;
        end else begin
            est_q    <= est_d;
            sr_q     <= sr_d;
            lat_q    <= lat_d;
            ult_q    <= ult_d;
            acc_q    <= acc_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            pronto_q <= pronto_d;
            for (int i = 0; i < 5; i++)
                hex_q[i] <= hex_d[i];
        end
    end

    assign bcd     = bcd_q;
    assign hex0    = hex_q[0];
    assign hex1    = hex_q[1];
    assign hex2    = hex_q[2];
    assign hex3    = hex_q[3];
    assign hex4    = hex_q[4];
    assign pronto  = pronto_q;
    assign ocupado = (est_q != OCIOSO);

endmodule

// File: doc/conversor_display.md
# conversor_display

Display stage downstream of the stopwatch counter. Takes the 15-bit tenths-of-second value from the counter's `numout`, range 0..10000, and converts it to five BCD digits with a sequential double-dabble engine. It then drives five active-low 7-segment displays as `SSSS.d`. A conversion starts only when the input differs from the last published value, so a paused or idle counter causes no activity.

## Interface
- `WIDTH`, default 15: width of the input value.
- `DIGITS`, default 5: number of BCD digits and displays. Bench and top level use the defaults only.
- `clk  in  1`: system clock, 50 MHz board clock. Single clock domain.
- `rst  in  1`: reset, asynchronous and active-high. All state clears immediately on assertion.
- `valor  in  15`: binary value to display, sampled only in state `OCIOSO`.
- `bcd  out  20`: published BCD digits. `[3:0]` = tenths, `[7:4]` = units, up to `[19:16]` = thousands of seconds.
- `hex0..hex4  out  7 each`: segment lines {g,f,e,d,c,b,a}, active-low (0 = lit). `hex0` = tenths.
- `ocupado  out  1`: high while a conversion is in flight.
- `pronto  out  1`: one-cycle pulse on the cycle the outputs update.

## Operation
- The FSM has three states: `OCIOSO`, `CONVERTE`, `PUBLICA`.
- `OCIOSO`:
  - If `valor != ultimo`: latch `valor` into the shift register, clear the 20-bit BCD accumulator, set the iteration count to 0, go to `CONVERTE`.
  - Otherwise stay in `OCIOSO`.
- `CONVERTE`, one iteration per cycle:
  - Each nibble ≥5 gets +3 (all nibbles in parallel, on pre-shift values).
  - Then shift {accumulator, shift register} left by 1.
  - After iteration 15 (count == WIDTH-1), go to `PUBLICA`.
- `PUBLICA`:
  - Register `bcd`, all `hex*`, and `ultimo <= latched value`.
  - Pulse `pronto`.
  - Return to `OCIOSO`.
- Changes on `valor` during `CONVERTE`/`PUBLICA` are ignored. They are picked up by the `OCIOSO` comparison afterwards, so the final stable value is always displayed eventually.
- Any 15-bit input up to 32767 must convert correctly, even though the counter never exceeds 10000. No saturation or clamping.
- The decimal point is lit on `hex1` only, and is not part of the 7-bit bus. It is driven as a separate constant-low `dp1` inside the top level, outside this block.
- Segment encoding for digits 0-9 is standard. Codes 10-15 cannot occur and decode to all-off (7'h7F).
- `ocupado` is high in `CONVERTE` and `PUBLICA`, low in `OCIOSO`.

## Timing
- Reset values:
  - State `OCIOSO`, `ultimo` = 0, `bcd` = 0.
  - `pronto` = 0, `ocupado` = 0.
  - `hex0..hex4` = the display of value 0 per Configuration. Without blanking this is 7'h40 on all five. With blanking: hex0 = hex1 = 7'h40, hex2..hex4 = 7'h7F.
- Latency:
  - `valor` is sampled at edge N (in `OCIOSO`).
  - 15 `CONVERTE` edges follow: N+1..N+15.
  - Outputs and `pronto` are valid after edge N+16.
  - The earliest next sample is edge N+17.
  - Worst-case issue-to-display time is 33 cycles, below the counter's 5,000,000-cycle tick.
- Outputs hold between publications. No glitching on `hex*` during conversion.
- Reset asserted mid-conversion aborts it immediately: outputs return to reset values and no `pronto` is issued. After release, a nonzero `valor` starts a fresh conversion on the first edge.
- A `valor` equal to `ultimo` never starts a conversion, including a value of 0 after reset.

## Configuration
- `CONVERSOR_BLANK_EN` defined:
  - Leading-zero suppression: `hex4`, `hex3`, `hex2` are blanked (7'h7F) while they and every more-significant digit are 0.
  - `hex1` and `hex0` are always shown, so 0 reads ` 0.0`.
  - Blanking is decided at `PUBLICA` and registered with the segments.
- Not defined: all five digits always shown, e.g. `00000`-style `0000.0`.
- `bcd` is identical in both builds.

## Structure
- Package `conversor_pkg`:
  - State enum {OCIOSO, CONVERTE, PUBLICA}.
  - Constants SEG_BLANK = 7'h7F and the ten segment codes SEG_0..SEG_9.
  - `WIDTH`/`DIGITS` defaults.
- Sub-module `bcd_para_7seg`: combinational 4-bit to 7-bit active-low decoder with a blank input. Instantiated five times on the registered-path inputs.
- The double-dabble datapath and FSM live in `conversor_display`.

## Test plan
- Reset, then hold `valor`=0 for 50 cycles → no `pronto`, `ocupado`=0, `bcd`=0.
  - Without the macro: hex0..4 = 7'h40.
  - With the macro: hex0 = hex1 = 7'h40, hex2..4 = 7'h7F.
- Step `valor` 0→123 at edge N → `pronto` seen exactly at edge N+16.
  - `bcd` = 20'h00123; hex0 = SEG_3, hex1 = SEG_2, hex2 = SEG_1.
  - Only `pronto` pulses after that; no further conversions.
- `valor`=10000 → `bcd` = 20'h10000.
  - With blanking: hex4 = SEG_1, hex3..hex0 = SEG_0.
- Max input 32767 → `bcd` = 20'h32767.
- Change `valor` 5→9 at N and 9→42 at N+5 → first publication at N+16 shows 9, second at N+33 shows 42. `pronto` pulses twice.
- Assert `rst` at N+8 of a conversion of 777 → outputs return to reset values at once and no `pronto`. After release with `valor`=777, 777 is published 17 cycles later.
